// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, multiply/divide sequencer states and default latencies.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    // Memory stage wins over Writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        if (src != 5'd0 && reg_write_m && src == write_reg_m) begin
            return FWD_MEM;
        end else if (src != 5'd0 && reg_write_w && src == write_reg_w) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; the pipeline is the
// master, the controller the slave.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  rsD, rtD, rsE, rtE;
    logic [4:0]  writeRegE, writeRegM, writeRegW;
    logic        regWriteE, regWriteM, regWriteW;
    logic        memToRegE, memToRegM;
    logic        branchD, jumpD, pcSrcD;
    logic        mduStartE, mduOpE;
    logic        stallF, stallD, flushD, flushE;
    logic [1:0]  forwardAE, forwardBE;
    logic        forwardAD, forwardBD;
    logic        mduBusy, mduDone;
    logic [15:0] stallCount;

    modport master (
        output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
               branchD, jumpD, pcSrcD, mduStartE, mduOpE,
        input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
               forwardAD, forwardBD, mduBusy, mduDone, stallCount
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
               branchD, jumpD, pcSrcD, mduStartE, mduOpE,
        output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
               forwardAD, forwardBD, mduBusy, mduDone, stallCount
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide occupancy sequencer: IDLE -> BUSY (N cycles) -> DONE -> IDLE.
// Starts are only accepted in IDLE.
module mdu_sequencer
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic mdu_start,
    input  logic mdu_op,
    output logic mdu_busy,
    output logic mdu_done
);

    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    mdu_state_e state_d, state_q;
    logic [7:0] count_d, count_q;
    logic       busy_d, busy_q;
    logic       done_d, done_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (mdu_start) begin
                    state_d = BUSY;
                    count_d = mdu_op ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (count_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mdu_busy = busy_q;
    assign mdu_done = done_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use and branch
// stalls, control flushes, multi-cycle MDU stall and a saturating stall counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input logic CLK,
    input logic RST,
    pipeline_hazard_ctrl_if.slave hz
);

    logic        lw_stall, br_stall, stall;
    logic        rs_br_hit, rt_br_hit;
    logic        mdu_busy, mdu_done;
    logic [15:0] stall_count_d, stall_count_q;

    mdu_sequencer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_mdu_sequencer (
        .CLK      (CLK),
        .RST      (RST),
        .mdu_start(hz.mduStartE),
        .mdu_op   (hz.mduOpE),
        .mdu_busy (mdu_busy),
        .mdu_done (mdu_done)
    );

    // A branch resolved in Decode needs its operands before Execute or a
    // pending load in Memory can supply them.
    always_comb begin
        lw_stall  = hz.memToRegE && (hz.rtE != 5'd0) &&
                    ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
        rs_br_hit = (hz.rsD != 5'd0) &&
                    ((hz.regWriteE && hz.writeRegE == hz.rsD) ||
                     (hz.memToRegM && hz.writeRegM == hz.rsD));
        rt_br_hit = (hz.rtD != 5'd0) &&
                    ((hz.regWriteE && hz.writeRegE == hz.rtD) ||
                     (hz.memToRegM && hz.writeRegM == hz.rtD));
        br_stall  = hz.branchD && (rs_br_hit || rt_br_hit);
        stall     = lw_stall || br_stall || mdu_busy;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.stallF     = stall;
    assign hz.stallD     = stall;
    assign hz.flushE     = stall;
    assign hz.flushD     = (hz.pcSrcD || hz.jumpD) && !stall;
    assign hz.forwardAE  = fwd_sel(hz.rsE, hz.regWriteM, hz.writeRegM, hz.regWriteW, hz.writeRegW);
    assign hz.forwardBE  = fwd_sel(hz.rtE, hz.regWriteM, hz.writeRegM, hz.regWriteW, hz.writeRegW);
    assign hz.forwardAD  = (hz.rsD != 5'd0) && hz.regWriteM && (hz.rsD == hz.writeRegM);
    assign hz.forwardBD  = (hz.rtD != 5'd0) && hz.regWriteM && (hz.rtD == hz.writeRegM);
    assign hz.mduBusy    = mdu_busy;
    assign hz.mduDone    = mdu_done;
    assign hz.stallCount = stall_count_q;

endmodule
